// File: rtl/alb_arbiter.sv
// alb_arbiter: round-robin arbiter sharing one `alb` ALU between NUM_REQ requesters.
// One operation in flight; result returned through a valid/ready response channel
// tagged with the issuing requester's ID.
// Optional: define ALB_ARB_PERF_EN to add a saturating 16-bit op_count output.
module alb_arbiter #(
    parameter int DATA_WIDTH  = 11,
    parameter int NUM_REQ     = 4,
    parameter int ALB_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]              req_ci,
    input  logic [NUM_REQ*2-1:0]            req_i,
    output logic [DATA_WIDTH-1:0]           alb_a,
    output logic [DATA_WIDTH-1:0]           alb_b,
    output logic                            alb_ci,
    output logic [1:0]                      alb_i,
    input  logic [DATA_WIDTH-1:0]           alb_f,
    input  logic                            alb_co,
    input  logic                            alb_vo,
    input  logic                            alb_no,
    input  logic                            alb_zo,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [DATA_WIDTH-1:0]           rsp_f,
    output logic [3:0]                      rsp_flags
`ifdef ALB_ARB_PERF_EN
    ,
    output logic [15:0]                     op_count
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pend_id;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] idx;
    logic            grant_any;
    logic [2:0]      counter;

    // Round-robin search: first valid requester after the previous winner, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((32'(last_grant) + off) % NUM_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // Next-state and grant decode; no grant is shown while reset is asserted
    // because the coming edge would discard it anyway.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_id] = reset;
                    state_nxt           = WAIT;
                end
            end
            WAIT: begin
                if (counter == 3'(ALB_LATENCY)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, latency counter and response capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter    <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            pend_id    <= '0;
            alb_a      <= '0;
            alb_b      <= '0;
            alb_ci     <= 1'b0;
            alb_i      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_f      <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alb_a      <= req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
                        alb_b      <= req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
                        alb_ci     <= req_ci[grant_id];
                        alb_i      <= req_i[grant_id*2 +: 2];
                        last_grant <= grant_id;
                        pend_id    <= grant_id;
                        counter    <= '0;
                    end
                end
                WAIT: begin
                    if (counter == 3'(ALB_LATENCY)) begin
                        rsp_f     <= alb_f;
                        rsp_flags <= {alb_co, alb_vo, alb_no, alb_zo};
                        rsp_id    <= pend_id;
                        rsp_valid <= 1'b1;
                    end else begin
                        counter <= counter + 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALB_ARB_PERF_EN
    // Completed-response counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready && (op_count != '1)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/alb_arbiter.md
Name: alb_arbiter

Overview:
- Shares one `alb` ALU instance between NUM_REQ requesters, with one operation in flight at a time.
- Each requester presents a, b, ci and i through a valid/ready handshake. A round-robin grant selects one.
- The arbiter drives the ALU with registered operands and waits ALB_LATENCY cycles.
- It then returns f and flags {co,vo,no,zo}, tagged with the requester ID, through a valid/ready response channel.

Parameters:
- DATA_WIDTH, 11, operand/result width; must match the `alb` instance.
- NUM_REQ, 4, number of requesters, range 2..16.
- ALB_LATENCY, 1, clock edges from `alb` inputs changing to `alb` f/flags valid; range 0..7.
- ID_W (localparam), $clog2(NUM_REQ), requester ID width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, at most one bit high.
- req_a  input  NUM_REQ*DATA_WIDTH  operand a; slice k belongs to requester k.
- req_b  input  NUM_REQ*DATA_WIDTH  operand b, packed the same way.
- req_ci  input  NUM_REQ  carry-in.
- req_i  input  NUM_REQ*2  opcode.
- alb_a  output  DATA_WIDTH  to `alb` a.
- alb_b  output  DATA_WIDTH  to `alb` b.
- alb_ci  output  1  to `alb` ci.
- alb_i  output  2  to `alb` i.
- alb_f  input  DATA_WIDTH  from `alb` f.
- alb_co, alb_vo, alb_no, alb_zo  input  1 each  `alb` flags.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  index of the requester that issued the op.
- rsp_f  output  DATA_WIDTH  captured result.
- rsp_flags  output  4  captured {co,vo,no,zo}.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, counter=0, last_grant=NUM_REQ-1 so requester 0 wins first.
  - alb_a, alb_b, alb_ci, alb_i = 0.
  - rsp_valid, rsp_id, rsp_f, rsp_flags = 0.
- req_ready is combinational from state and req_valid. It is nonzero only in IDLE.
- Reset mid-operation discards the in-flight op. No response is produced for it.
- IDLE:
  - If any req_valid is high, the winner g is the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g]=1 in the same cycle.
  - At the edge: latch slice g into alb_*, store g as last_grant and pending ID, counter=0, go to WAIT.
  - If no req_valid is high: stay in IDLE, req_ready=0.
- WAIT:
  - If counter==ALB_LATENCY, capture alb_f and flags into rsp_f/rsp_flags, set rsp_id, set rsp_valid=1, go to RESP.
  - Otherwise counter+1.
- RESP:
  - rsp_valid=1; rsp_* stay stable while rsp_ready=0.
  - On rsp_ready=1 at the edge: rsp_valid=0, go to IDLE.
  - No grant is issued while in RESP.
- Latency, request handshake at cycle 0:
  - rsp_valid is first high in cycle ALB_LATENCY+2.
  - With rsp_ready tied high, the earliest next grant is in cycle ALB_LATENCY+3.
- alb_* hold their last operands between operations and are not cleared after use.
- Requester rule: once valid is high, valid and payload stay stable until ready. The bench checks this with an assertion; the arbiter does not.
- A requester that deasserts valid before being granted is simply skipped.
- Simultaneous requests: exactly one is granted; the others keep waiting.
- Starvation bound: a continuously valid requester is granted within NUM_REQ grants.
- No width conversion: operands and result pass through at DATA_WIDTH bits.

Optional Feature:
- Macro: ALB_ARB_PERF_EN.
- When defined:
  - Adds output op_count, 16 bits.
  - Increments on each response handshake (rsp_valid & rsp_ready), saturating at 16'hFFFF.
  - Cleared by reset.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_valid=4'hF -> req_ready=0, rsp_valid=0, alb_*=0; after release, requester 0 is granted first.
- Single op: requester 2 sends a=11'h005, b=11'h003, ci=0, i=2'b00; stub `alb` gives f=11'h123, flags 4'b0100 at L=1 -> alb_a=5 and alb_b=3 in cycle 1; rsp_valid in cycle 3 with rsp_id=2, rsp_f=11'h123, rsp_flags=4'b0100.
- Round robin: req_valid=4'hF held, rsp_ready=1 -> grant order 0,1,2,3,0,1; with only requesters 1 and 3 valid -> order 1,3,1,3.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable and req_ready=0 throughout; on rsp_ready=1, IDLE next cycle and the next grant follows.
- Reset mid-WAIT: assert reset during WAIT with ALB_LATENCY=3 -> rsp_valid never rises; after release, requester 0 is granted.
- PERF (ALB_ARB_PERF_EN): 3 completed ops -> op_count=3; preload near saturation via a long run -> holds at 16'hFFFF.
